// File: rtl/sys_ctrl.sv
// sys_ctrl: byte-command controller between the UART receiver, the register
// file, the ALU and the TX FIFO. One command byte is followed by its operand
// bytes. Read and ALU results are buffered and pushed into the TX FIFO
// (with back-pressure). The ALU result is sent as two bytes, LSB first.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [DATA_WIDTH-1:0]   RX_P_Data,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  // FSM encoding; codes 12..15 are unused and fall back to IDLE.
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] RD_SEND  = 4'd5;
  localparam logic [3:0] OP_A     = 4'd6;
  localparam logic [3:0] OP_B     = 4'd7;
  localparam logic [3:0] FUN      = 4'd8;
  localparam logic [3:0] ALU_WAIT = 4'd9;
  localparam logic [3:0] SEND_LSB = 4'd10;
  localparam logic [3:0] SEND_MSB = 4'd11;

  // Command bytes recognised in IDLE.
  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  // Fixed register-file slots for the two ALU operands.
  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

  logic [3:0]              state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;     // write address from WR_ADDR
  logic [DATA_WIDTH-1:0]   rd_buf_q,  rd_buf_d;   // read data waiting for TX
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;  // ALU result waiting for TX

  // Next-state, buffer updates and all outputs; outputs are decoded from the
  // current state so that IDLE (and therefore reset) drives every output to 0.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    rd_buf_d    = rd_buf_q;
    alu_res_d   = alu_res_q;
    Address     = '0;
    WrEn        = 1'b0;
    RdEn        = 1'b0;
    WrData      = '0;
    ALU_FUN     = 4'd0;
    ALU_EN      = 1'b0;
    CLK_GATE_EN = 1'b0;
    TX_P_DATA   = '0;
    TX_D_VLD    = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_Data)
            CMD_WR:      state_d = WR_ADDR;
            CMD_RD:      state_d = RD_ADDR;
            CMD_ALU_OP:  state_d = OP_A;
            CMD_ALU_NOP: state_d = FUN;
            default:     state_d = IDLE;   // unknown command byte is dropped
          endcase
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_Data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = addr_q;
          WrData  = RX_P_Data;
          state_d = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          RdEn    = 1'b1;
          Address = RX_P_Data[ADDR_WIDTH-1:0];
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (RdData_Valid) begin
          rd_buf_d = RdData;
          state_d  = RD_SEND;
        end
      end

      RD_SEND: begin
        // Hold the byte until the FIFO has room; nothing is lost while full.
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = rd_buf_q;
          state_d   = IDLE;
        end
      end

      OP_A: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = OPA_ADDR;
          WrData  = RX_P_Data;
          state_d = OP_B;
        end
      end

      OP_B: begin
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = OPB_ADDR;
          WrData  = RX_P_Data;
          state_d = FUN;
        end
      end

      FUN: begin
        // The ALU clock stays ungated from opcode wait until the result lands.
        CLK_GATE_EN = 1'b1;
        if (RX_D_VLD) begin
          ALU_EN  = 1'b1;
          ALU_FUN = RX_P_Data[3:0];
          state_d = ALU_WAIT;
        end
      end

      ALU_WAIT: begin
        CLK_GATE_EN = 1'b1;
        if (ALU_OUT_VLD) begin
          alu_res_d = ALU_OUT;
          state_d   = SEND_LSB;
        end
      end

      SEND_LSB: begin
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = alu_res_q[DATA_WIDTH-1:0];
          state_d   = SEND_MSB;
        end
      end

      SEND_MSB: begin
        if (!FIFO_FULL) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset returns to IDLE with buffers cleared.
  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_buf_q  <= '0;
      alu_res_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_buf_q  <= rd_buf_d;
      alu_res_q <= alu_res_d;
    end
  end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte / register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have port CLK  input  1  system clock, all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_P_Data  input  DATA_WIDTH  byte delivered by the UART receiver.
REQ-006 SHALL have port RX_D_VLD  input  1  one-cycle strobe; RX_P_Data is valid in that cycle.
REQ-007 SHALL have port RdData / RdData_Valid  input  DATA_WIDTH / 1  register-file read data and its one-cycle valid.
REQ-008 SHALL have port ALU_OUT / ALU_OUT_VLD  input  2*DATA_WIDTH / 1  ALU result and its one-cycle valid.
REQ-009 SHALL have port FIFO_FULL  input  1  TX FIFO cannot accept a write.
REQ-010 SHALL have port Address / WrEn / RdEn / WrData  output  ADDR_WIDTH / 1 / 1 / DATA_WIDTH  register-file access.
REQ-011 SHALL have port ALU_FUN / ALU_EN / CLK_GATE_EN  output  4 / 1 / 1  ALU opcode, one-cycle start, and ALU clock-gate enable.
REQ-012 SHALL have port TX_P_DATA / TX_D_VLD  output  DATA_WIDTH / 1  TX FIFO write data and one-cycle write strobe.

Function
REQ-013 SHALL decode the first byte accepted in IDLE as a command: 0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operands; any other value SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-014 SHALL implement the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, OP_A, OP_B, FUN, ALU_WAIT, SEND_LSB and SEND_MSB; unused encodings SHALL return to IDLE with all strobes low.
REQ-015 SHALL advance a byte-consuming state (IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN) only in a cycle with RX_D_VLD=1.
REQ-016 SHALL, for 0xAA, latch RX_P_Data[ADDR_WIDTH-1:0] in WR_ADDR, then in WR_DATA drive WrEn=1, Address=latched address and WrData=RX_P_Data combinationally for that one cycle, then go to IDLE.
REQ-017 SHALL, for 0xBB, drive RdEn=1 and Address=RX_P_Data[ADDR_WIDTH-1:0] for one cycle in RD_ADDR, go to RD_WAIT, capture RdData into the TX buffer on RdData_Valid, and go to RD_SEND.
REQ-018 SHALL, for 0xCC, write the OP_A byte to address 0 and the OP_B byte to address 1 (WrEn one cycle each, as in REQ-016), then go to FUN.
REQ-019 SHALL, for 0xDD, go directly from IDLE to FUN.
REQ-020 SHALL, in FUN on RX_D_VLD, drive ALU_EN=1 and ALU_FUN=RX_P_Data[3:0] for one cycle, then go to ALU_WAIT.
REQ-021 SHALL, in ALU_WAIT, capture ALU_OUT on ALU_OUT_VLD and go to SEND_LSB.
REQ-022 SHALL hold CLK_GATE_EN=1 throughout FUN and ALU_WAIT, and 0 in all other states.
REQ-023 SHALL, in RD_SEND, SEND_LSB and SEND_MSB, drive TX_D_VLD=1 with the buffered byte (read data, ALU_OUT[7:0], ALU_OUT[15:8] respectively) only when FIFO_FULL=0, then advance (RD_SEND→IDLE, SEND_LSB→SEND_MSB, SEND_MSB→IDLE).
REQ-024 SHALL, while FIFO_FULL=1, hold the current send state with TX_D_VLD=0 and no data loss.
REQ-025 SHALL ignore RX_D_VLD in RD_WAIT, RD_SEND, ALU_WAIT, SEND_LSB and SEND_MSB; such bytes are dropped.
REQ-026 SHALL keep every strobe (WrEn, RdEn, ALU_EN, TX_D_VLD) at most one cycle per event and never assert WrEn and RdEn in the same cycle.

Reset
REQ-027 SHALL, while Reset=0, force state IDLE, clear all buffers, and drive every output to 0, regardless of the operation in progress.
REQ-028 SHALL, after Reset is released, accept a new command starting in the first cycle.

Verification
REQ-029 Write: bytes 0xAA,0x05,0x3C -> exactly one WrEn pulse with Address=5 and WrData=0x3C; FSM ends in IDLE.
REQ-030 Read: 0xBB,0x05, then RdData=0x3C with RdData_Valid -> RdEn pulse with Address=5, then one TX_D_VLD with TX_P_DATA=0x3C.
REQ-031 ALU: 0xCC,0x07,0x03,0x00, then ALU_OUT=0x000A -> writes to addr0=0x07 and addr1=0x03, ALU_EN with ALU_FUN=0, TX bytes 0x0A then 0x00, CLK_GATE_EN high only in FUN/ALU_WAIT.
REQ-032 Backpressure: 0xDD,0x02, ALU_OUT=0x1234, FIFO_FULL=1 for 5 cycles -> no TX_D_VLD while full, then 0x34 then 0x12.
REQ-033 Illegal/extra: 0x55 -> no strobes, stays in IDLE; an RX byte during ALU_WAIT is dropped.
REQ-034 Reset in ALU_WAIT -> all outputs 0 immediately; a following 0xAA,0x01,0xFF executes correctly.
